// File: rtl/days_detector.sv
// Month-length classifier for the Darian Martian calendar.
// Registered outputs update one cycle after a qualified month/leap-year input.
module days_detector #(
  parameter int MONTHS    = 24,
  parameter int QUARTER   = 6,
  parameter int LONG_SOLS = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [4:0] m,
  input  logic       LY,
  output logic       d27,
  output logic       d28,
  output logic [4:0] days,
  output logic       invalid,
  output logic       valid_out
);

  logic [5:0] mp1;
  logic       last_of_qtr;
  logic       is_long;
  logic       is_short;
  logic       is_bad;
  logic [4:0] nxt_days;

  assign mp1         = {1'b0, m} + 6'd1;
  assign last_of_qtr = ((32'(mp1) % QUARTER) == 0);

  // The final month of the year regains its 28th sol in a leap year.
  always_comb begin
    is_long  = 1'b0;
    is_short = 1'b0;
    is_bad   = 1'b0;
    if (32'(m) >= MONTHS)
      is_bad = 1'b1;
    else if (last_of_qtr && !((32'(m) == MONTHS - 1) && LY))
      is_short = 1'b1;
    else
      is_long = 1'b1;
  end

  always_comb begin
    nxt_days = 5'd0;
    if (is_long)       nxt_days = 5'(LONG_SOLS);
    else if (is_short) nxt_days = 5'(LONG_SOLS - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d27       <= 1'b0;
      d28       <= 1'b0;
      days      <= 5'd0;
      invalid   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        d27     <= is_short;
        d28     <= is_long;
        days    <= nxt_days;
        invalid <= is_bad;
      end
    end
  end

endmodule

// File: tb/tb_days_detector.sv
// Directed plan plus randomized stream for days_detector, checked against
// a calendar-rule model held in the bench.
module tb_days_detector;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [4:0] m = 5'd0;
  logic       LY = 1'b0;
  logic       d27, d28, invalid, valid_out;
  logic [4:0] days;

  int total = 0;
  int bad   = 0;

  // model state: what the registered outputs should hold
  int e_days = 0;
  bit e_inv  = 0;
  bit e_vout = 0;

  days_detector dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .m(m), .LY(LY),
    .d27(d27), .d28(d28), .days(days), .invalid(invalid), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic int sols_of(int mon, bit leap);
    if (mon > 23) return 0;
    if (mon == 23) return leap ? 28 : 27;
    if (mon % 6 == 5) return 27;
    return 28;
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit v, int mon, bit leap, string tag);
    @(negedge clk);
    rst = r; valid_in = v; m = 5'(mon); LY = leap;
    @(posedge clk);
    #1;
    if (r) begin
      e_days = 0; e_inv = 0; e_vout = 0;
    end else begin
      e_vout = v;
      if (v) begin
        e_days = sols_of(mon, leap);
        e_inv  = (mon > 23);
      end
    end
    chk({tag, ".days"},  8'(days),      8'(e_days));
    chk({tag, ".d27"},   8'(d27),       8'(e_days == 27));
    chk({tag, ".d28"},   8'(d28),       8'(e_days == 28));
    chk({tag, ".inv"},   8'(invalid),   8'(e_inv));
    chk({tag, ".vout"},  8'(valid_out), 8'(e_vout));
    chk({tag, ".excl"},  8'(d27 & d28), 8'd0);
  endtask

  initial begin
    // reset held with valid input present
    step(1, 1, 0, 0, "rst0");
    step(1, 1, 0, 0, "rst1");
    step(0, 1, 0, 0, "rel");
    // sweep regular months, no leap
    for (int i = 0; i < 23; i++) step(0, 1, i, 0, "sweep");
    // leap toggle on the final month
    step(0, 1, 23, 0, "m23_ly0");
    step(0, 1, 23, 1, "m23_ly1");
    step(0, 1, 23, 0, "m23_ly0b");
    // out-of-range months
    for (int i = 24; i < 32; i++) begin
      step(0, 1, i, 0, "bad_ly0");
      step(0, 1, i, 1, "bad_ly1");
    end
    // hold when not qualified
    step(0, 1, 5, 0, "hold_ld");
    step(0, 0, 0, 0, "hold0");
    step(0, 0, 23, 1, "hold1");
    // mid-stream reset
    step(0, 1, 10, 0, "mid10");
    step(1, 1, 11, 0, "mid_rst");
    step(0, 1, 12, 0, "mid12");
    step(0, 1, 11, 1, "mid11");
    // randomized stream
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rnd");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/days_detector.md
Name: days_detector

Overview:
- Month-length classifier for the Martian (Darian-style) calendar.
- 24 months per year, zero-based index 0..23. Every 6th month (index 5, 11, 17, 23) is a 27-sol month. All other valid months are 28 sols.
- Exception: month 23 is a 28-sol month in a leap year.
- Registered outputs, one-cycle latency. Sits between the calendar month counter and sol-rollover logic.

Parameters:
- MONTHS, 24, number of valid months per year (indices 0..MONTHS-1).
- QUARTER, 6, months per quarter; the last month of each quarter is short.
- LONG_SOLS, 28, sol count of a long month.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- valid_in  input  1  qualifies m/LY this cycle
- m  input  5  zero-based month index
- LY  input  1  1 = leap year
- d27  output  1  registered: month has 27 sols
- d28  output  1  registered: month has 28 sols
- days  output  5  registered sol count: 27, 28, or 0 when invalid
- invalid  output  1  registered: m >= MONTHS
- valid_out  output  1  registered copy of valid_in

Behaviour:
- Reset (rst=1 at a clk edge): d27=0, d28=0, days=0, invalid=0, valid_out=0. Reset has priority over valid_in.
- valid_out <= valid_in on every non-reset edge.
- When valid_in=1 on a non-reset edge, d27/d28/days/invalid load from the combinational decode of m and LY. Latency is exactly 1 cycle.
- When valid_in=0, d27/d28/days/invalid hold their previous values.
- Decode:
  - short = ((m+1) mod QUARTER == 0), i.e. m in {5, 11, 17, 23}.
  - m < MONTHS and not short: d27=0, d28=1, days=28, invalid=0.
  - m in {5, 11, 17}: d27=1, d28=0, days=27, invalid=0. LY is ignored.
  - m == MONTHS-1 (23), LY=0: d27=1, d28=0, days=27.
  - m == 23, LY=1: d27=0, d28=1, days=28.
  - m >= MONTHS (24..31): d27=0, d28=0, days=0, invalid=1, regardless of LY.
- Invariant: d27 and d28 are never both 1. days == 27 iff d27; days == 28 iff d28.
- LY affects outputs only for m == 23.
- Decode must be a pure function of m and LY (no internal year state). A change of LY while m is held re-evaluates on the next valid edge.
- Reset asserted mid-stream clears all outputs on that edge. The first valid_in after reset release produces a result one cycle later.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_in=1, m=0 -> all outputs 0, valid_out=0. Release -> next cycle d28=1, days=28, valid_out=1.
- Sweep m=0..22 with valid_in=1, LY=0 -> one cycle later, d27=1/days=27 only for m=5, 11, 17; d28=1/days=28 for all others; invalid=0 throughout.
- Hold m=23, toggle LY 0->1->0 -> d27=1,d28=0,days=27 -> d27=0,d28=1,days=28 -> back to 27, each one cycle after the LY change.
- Sweep m=24..31 with LY=0 and LY=1 -> d27=0, d28=0, days=0, invalid=1 in every case.
- Hold check: m=5 valid, then valid_in=0 with m=0 -> outputs stay d27=1, days=27; valid_out drops to 0 one cycle later.
- Mid-operation reset: pulse rst during a valid sweep at m=11 -> outputs 0 on that edge; decoding resumes with the next valid input.
